asymfifo_s1_xw: RTL and testbench
=================================

ASYMFIFO_S1_XW -- requirements
Module: asymfifo_s1_xw

Interface
REQ-001 SHALL have parameter IN_W, default 8, push data width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, pop data width; max(IN_W,OUT_W)/min(IN_W,OUT_W) = R SHALL be 1, 2, 4, 8 or 16.
REQ-003 SHALL have parameter DEPTH, default 4, RAM words of width W = max(IN_W,OUT_W), range 2..256.
REQ-004 SHALL have parameter ERR_MODE, default 0: 0 = sticky error, 1 = error for one cycle.
REQ-005 SHALL have parameter BYTE_ORDER, default 0: 0 = first-pushed/first-popped slice in MSBs, 1 = in LSBs.
REQ-006 SHALL derive AW = ceil(log2(DEPTH+1)).
REQ-007 SHALL have ports: clk in 1, sole clock, rising edge.
REQ-008 SHALL have port rst in 1, asynchronous active-high reset.
REQ-009 SHALL have ports: push_req_n in 1, active-low push; pop_req_n in 1, active-low pop; flush_n in 1, active-low partial-word flush.
REQ-010 SHALL have ports: data_in in IN_W; ae_level in AW; af_level in AW.
REQ-011 SHALL have outputs: empty, almost_empty, half_full, almost_full, ram_full, full, error, part_wd (1 bit each); word_count AW; data_out OUT_W.

Function
REQ-012 All outputs except data_out SHALL be registered, updating on the clk edge that performs the operation.
REQ-013 Upsize (IN_W<OUT_W): accepted push SHALL load data_in into the next slice of an input accumulator; the R-th push SHALL write accumulator plus data_in to RAM in that cycle; word_count +1.
REQ-014 part_wd SHALL be 1 while the accumulator holds 1..R-1 slices; always 0 when IN_W>=OUT_W.
REQ-015 Flush (flush_n=0, part_wd=1, ram_full=0) SHALL write the partial word, unfilled slices zero, clear accumulator; push in same cycle SHALL be appended before the write.
REQ-016 Flush with part_wd=0, or with IN_W>=OUT_W, SHALL have no effect; flush with part_wd=1 and ram_full=1 SHALL flag error and keep accumulator.
REQ-017 Downsize (IN_W>OUT_W): push SHALL write one RAM word; pop SHALL consume one OUT_W slice; the head word SHALL be freed (word_count -1) after its R-th slice.
REQ-018 R=1: SHALL behave as a plain synchronous FIFO.
REQ-019 data_out SHALL combinationally show the current head slice (full word when OUT_W>=IN_W); 0 when empty.
REQ-020 ram_full = (word_count==DEPTH); full = ram_full AND (upsize: accumulator holds R-1 slices; else 1).
REQ-021 Push while full SHALL be rejected (overflow error), state unchanged; pop in the same cycle SHALL NOT enable the push.
REQ-022 Pop while empty SHALL be rejected (underflow error); a simultaneous push SHALL still be accepted.
REQ-023 Simultaneous push and pop when neither full nor empty SHALL both complete; word_count adjusts by net change.
REQ-024 empty = (word_count==0); accumulator contents SHALL NOT clear empty.
REQ-025 almost_empty = (word_count <= ae_level); half_full = (word_count >= ceil(DEPTH/2)); almost_full = (word_count >= DEPTH - af_level), evaluated against live levels.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-027 ERR_MODE=0: error SHALL stay 1 until reset; ERR_MODE=1: error SHALL be 1 only the cycle after an offending request.

Reset
REQ-028 rst=1 SHALL immediately force: empty=1, almost_empty=1, all other flags 0, error=0, word_count=0, data_out=0, pointers, slice index and accumulator cleared; RAM contents not reset.
REQ-029 Reset mid-operation SHALL discard stored and partial data; first push after rst deassert SHALL start at slice 0.

Verification (IN_W=8, OUT_W=32, DEPTH=4, BYTE_ORDER=0 unless stated)
REQ-030 Push 0x11,0x22,0x33,0x44 -> empty=0, word_count=1 after 4th edge; data_out=0x11223344; pop -> empty=1.
REQ-031 Push 0xAA,0xBB, then flush -> part_wd 1->0, word_count=1, data_out=0xAABB0000.
REQ-032 Push 19 bytes -> ram_full=1, full=1; 20th push -> error=1, word_count=4; pops return words in order.
REQ-033 Pop on empty with ERR_MODE=1 -> error=1 one cycle then 0; ERR_MODE=0 -> error stays 1.
REQ-034 IN_W=32, OUT_W=8: push 0xDEADBEEF -> four pops give 0xDE,0xAD,0xBE,0xEF; empty=1 after 4th; BYTE_ORDER=1 -> 0xEF first.
REQ-035 word_count=2, part_wd=1, assert rst asynchronously -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/asymfifo_s1_xw.sv
// Asymmetric-width synchronous FIFO: packs narrow pushes into wide RAM words
// (upsize), or splits wide RAM words into narrow pops (downsize).
module asymfifo_s1_xw #(
   parameter int unsigned IN_W       = 8,
   parameter int unsigned OUT_W      = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ERR_MODE   = 0,
   parameter int unsigned BYTE_ORDER = 0,
   localparam int unsigned AW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_req_n,
   input  logic             pop_req_n,
   input  logic             flush_n,
   input  logic [IN_W-1:0]  data_in,
   input  logic [AW-1:0]    ae_level,
   input  logic [AW-1:0]    af_level,
   output logic             empty,
   output logic             almost_empty,
   output logic             half_full,
   output logic             almost_full,
   output logic             ram_full,
   output logic             full,
   output logic             error,
   output logic             part_wd,
   output logic [AW-1:0]    word_count,
   output logic [OUT_W-1:0] data_out
);

   localparam int unsigned W   = (IN_W > OUT_W) ? IN_W : OUT_W;
   localparam int unsigned S   = (IN_W > OUT_W) ? OUT_W : IN_W;
   localparam int unsigned R   = W / S;
   localparam bit          UP  = (IN_W < OUT_W);
   localparam bit          DN  = (IN_W > OUT_W);
   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned SW  = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned AW1 = AW + 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [SW-1:0] SL_LAST  = SW'(R - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [W-1:0]  acc, acc_n, acc_ins, wr_data, head;
   logic [SW-1:0] acc_cnt, acc_cnt_n, rd_slice, rd_slice_n;
   logic [AW-1:0] wc_n;
   logic          push, pop, flush, push_ok, pop_ok, wr_en, word_done, bad;

   // Bit offset of slice k inside a wide word; slice 0 is the first in/out.
   function automatic int unsigned slice_off(input logic [SW-1:0] k);
      return (BYTE_ORDER == 0) ? (R - 1 - 32'(k)) * S : 32'(k) * S;
   endfunction

   assign push    = ~push_req_n;
   assign pop     = ~pop_req_n;
   assign flush   = ~flush_n;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Next-state: accumulator packing, RAM write, slice/word consumption.
   always_comb begin
      acc_n      = acc;
      acc_cnt_n  = acc_cnt;
      acc_ins    = acc;
      rd_slice_n = rd_slice;
      wr_ptr_n   = wr_ptr;
      rd_ptr_n   = rd_ptr;
      wr_en      = 1'b0;
      wr_data    = '0;
      word_done  = 1'b0;
      bad        = (push && full) || (pop && empty);
      if (UP) begin
         if (push_ok) acc_ins = acc | (W'(data_in) << slice_off(acc_cnt));
         acc_n     = acc_ins;
         acc_cnt_n = acc_cnt + SW'(push_ok);
         // A completing push wins over flush; flush into a full RAM keeps the partial word.
         if ((push_ok && acc_cnt == SL_LAST) || (flush && part_wd && !ram_full)) begin
            wr_en     = 1'b1;
            wr_data   = acc_ins;
            acc_n     = '0;
            acc_cnt_n = '0;
         end else if (flush && part_wd) begin
            bad = 1'b1;
         end
      end else if (push_ok) begin
         wr_en   = 1'b1;
         wr_data = W'(data_in);
      end
      if (pop_ok) begin
         if (DN && rd_slice != SL_LAST) begin
            rd_slice_n = rd_slice + SW'(1);
         end else begin
            rd_slice_n = '0;
            word_done  = 1'b1;
         end
      end
      if (wr_en)     wr_ptr_n = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (word_done) rd_ptr_n = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      wc_n = word_count + AW'(wr_en) - AW'(word_done);
   end

   // State and status flags, all derived from the post-operation count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         acc          <= '0;
         acc_cnt      <= '0;
         rd_slice     <= '0;
         word_count   <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         half_full    <= 1'b0;
         almost_full  <= 1'b0;
         ram_full     <= 1'b0;
         full         <= 1'b0;
         error        <= 1'b0;
         part_wd      <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_n;
         rd_ptr       <= rd_ptr_n;
         acc          <= acc_n;
         acc_cnt      <= acc_cnt_n;
         rd_slice     <= rd_slice_n;
         word_count   <= wc_n;
         empty        <= (wc_n == '0);
         almost_empty <= (wc_n <= ae_level);
         half_full    <= (wc_n >= AW'((DEPTH + 1) / 2));
         almost_full  <= (({1'b0, wc_n} + {1'b0, af_level}) >= AW1'(DEPTH));
         ram_full     <= (wc_n == AW'(DEPTH));
         full         <= (wc_n == AW'(DEPTH)) && (!UP || acc_cnt_n == SL_LAST);
         error        <= (ERR_MODE == 0) ? (error | bad) : bad;
         part_wd      <= UP && (acc_cnt_n != '0);
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Head slice presented combinationally, forced to zero while empty.
   always_comb begin
      head = mem[rd_ptr];
      if (empty)   data_out = '0;
      else if (DN) data_out = OUT_W'(head >> slice_off(rd_slice));
      else         data_out = OUT_W'(head);
   end

endmodule

// File: tb/tb_asymfifo_s1_xw.sv
// Scoreboard bench: an upsizing FIFO (8->32, depth 4, sticky error, MSB-first)
// and a downsizing FIFO (32->8, depth 3, one-cycle error, LSB-first) side by side.
module tb_asymfifo_s1_xw;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // upsize instance signals
   logic        u_push_n, u_pop_n, u_flush_n;
   logic [7:0]  u_din;
   logic [2:0]  u_ae, u_af, u_wc;
   logic        u_empty, u_aempty, u_hfull, u_afull, u_rfull, u_full, u_err, u_part;
   logic [31:0] u_dout;
   logic [7:0]  u_flags;
   // downsize instance signals
   logic        d_push_n, d_pop_n, d_flush_n;
   logic [31:0] d_din;
   logic [1:0]  d_ae, d_af, d_wc;
   logic        d_empty, d_aempty, d_hfull, d_afull, d_rfull, d_full, d_err, d_part;
   logic [7:0]  d_dout;
   logic [7:0]  d_flags;

   assign u_flags = {u_empty, u_aempty, u_hfull, u_afull, u_rfull, u_full, u_err, u_part};
   assign d_flags = {d_empty, d_aempty, d_hfull, d_afull, d_rfull, d_full, d_err, d_part};

   asymfifo_s1_xw #(.IN_W(8), .OUT_W(32), .DEPTH(4), .ERR_MODE(0), .BYTE_ORDER(0)) u_up (
      .clk(clk), .rst(rst), .push_req_n(u_push_n), .pop_req_n(u_pop_n), .flush_n(u_flush_n),
      .data_in(u_din), .ae_level(u_ae), .af_level(u_af),
      .empty(u_empty), .almost_empty(u_aempty), .half_full(u_hfull), .almost_full(u_afull),
      .ram_full(u_rfull), .full(u_full), .error(u_err), .part_wd(u_part),
      .word_count(u_wc), .data_out(u_dout));

   asymfifo_s1_xw #(.IN_W(32), .OUT_W(8), .DEPTH(3), .ERR_MODE(1), .BYTE_ORDER(1)) u_dn (
      .clk(clk), .rst(rst), .push_req_n(d_push_n), .pop_req_n(d_pop_n), .flush_n(d_flush_n),
      .data_in(d_din), .ae_level(d_ae), .af_level(d_af),
      .empty(d_empty), .almost_empty(d_aempty), .half_full(d_hfull), .almost_full(d_afull),
      .ram_full(d_rfull), .full(d_full), .error(d_err), .part_wd(d_part),
      .word_count(d_wc), .data_out(d_dout));

   typedef struct packed {
      logic [31:0] dout;
      logic [7:0]  wc;
      logic [7:0]  fl;
   } exp_t;

   exp_t        uexp_q[$], dexp_q[$];
   exp_t        me;
   int          checks = 0;
   int          passed = 0;

   // reference state: stored words, pending input bytes, current output slice
   logic [31:0] uq[$];
   logic [7:0]  ua[$];
   bit          uerr;
   logic [31:0] dq[$];
   int          ds;
   bit          derr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   function automatic logic [31:0] pack_up();
      logic [31:0] w = '0;
      foreach (ua[i]) w |= 32'(ua[i]) << (8 * (3 - i));
      return w;
   endfunction

   task automatic model_up(input bit push, input bit pop, input bit flush,
                           input logic [7:0] din, input int ae, input int af);
      int   n    = uq.size();
      bit   rf   = (n == 4);
      bit   fu   = rf && (ua.size() == 3);
      bit   em   = (n == 0);
      bit   part = (ua.size() != 0);
      bit   bad  = (push && fu) || (pop && em);
      exp_t e;
      if (pop && !em) void'(uq.pop_front());
      if (push && !fu) ua.push_back(din);
      if (ua.size() == 4) begin
         uq.push_back(pack_up());
         ua.delete();
      end else if (flush && part) begin
         if (rf) bad = 1'b1;
         else begin
            uq.push_back(pack_up());
            ua.delete();
         end
      end
      uerr = uerr | bad;
      n    = uq.size();
      e.wc   = 8'(n);
      e.fl   = {n == 0, n <= ae, n >= 2, n + af >= 4, n == 4, (n == 4) && (ua.size() == 3),
                uerr, ua.size() != 0};
      e.dout = (n == 0) ? 32'h0 : uq[0];
      uexp_q.push_back(e);
   endtask

   task automatic model_dn(input bit push, input bit pop, input logic [31:0] din,
                           input int ae, input int af);
      int   n  = dq.size();
      bit   fu = (n == 3);
      bit   em = (n == 0);
      exp_t e;
      derr = (push && fu) || (pop && em);
      if (pop && !em) begin
         ds++;
         if (ds == 4) begin
            void'(dq.pop_front());
            ds = 0;
         end
      end
      if (push && !fu) dq.push_back(din);
      n = dq.size();
      e.wc   = 8'(n);
      e.fl   = {n == 0, n <= ae, n >= 2, n + af >= 3, n == 3, n == 3, derr, 1'b0};
      e.dout = (n == 0) ? 32'h0 : ((dq[0] >> (8 * ds)) & 32'hFF);
      dexp_q.push_back(e);
   endtask

   // Drive one cycle on both instances (called at a falling edge, returns at the next).
   task automatic step(input bit up_push, input bit up_pop, input bit up_flush, input logic [7:0] ud,
                       input bit dn_push, input bit dn_pop, input bit dn_flush, input logic [31:0] dd);
      u_push_n = ~up_push; u_pop_n = ~up_pop; u_flush_n = ~up_flush; u_din = ud;
      d_push_n = ~dn_push; d_pop_n = ~dn_pop; d_flush_n = ~dn_flush; d_din = dd;
      model_up(up_push, up_pop, up_flush, ud, int'(u_ae), int'(u_af));
      model_dn(dn_push, dn_pop, dd, int'(d_ae), int'(d_af));
      @(negedge clk);
   endtask

   task automatic up_op(input bit push, input bit pop, input bit flush, input logic [7:0] d);
      step(push, pop, flush, d, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic dn_op(input bit push, input bit pop, input logic [31:0] d);
      step(1'b0, 1'b0, 1'b0, 8'h0, push, pop, 1'b0, d);
   endtask

   // Assert reset between edges and check that outputs clear before any clock edge.
   task automatic do_reset_check();
      u_push_n = 1'b1; u_pop_n = 1'b1; u_flush_n = 1'b1;
      d_push_n = 1'b1; d_pop_n = 1'b1; d_flush_n = 1'b1;
      rst = 1'b1;
      uq.delete(); ua.delete(); uerr = 1'b0;
      dq.delete(); ds = 0; derr = 1'b0;
      #1;
      chk("rst_up_flags", 32'(u_flags), 32'hC0);
      chk("rst_up_wc",    32'(u_wc),    32'h0);
      chk("rst_up_dout",  u_dout,       32'h0);
      chk("rst_dn_flags", 32'(d_flags), 32'hC0);
      chk("rst_dn_wc",    32'(d_wc),    32'h0);
      chk("rst_dn_dout",  32'(d_dout),  32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compare every post-edge DUT state with the queued expectation.
   always @(posedge clk) begin
      #1;
      if (!rst && uexp_q.size() > 0) begin
         me = uexp_q.pop_front();
         chk("up_dout",  u_dout,        me.dout);
         chk("up_wc",    32'(u_wc),     32'(me.wc));
         chk("up_flags", 32'(u_flags),  32'(me.fl));
      end
      if (!rst && dexp_q.size() > 0) begin
         me = dexp_q.pop_front();
         chk("dn_dout",  32'(d_dout),   me.dout);
         chk("dn_wc",    32'(d_wc),     32'(me.wc));
         chk("dn_flags", 32'(d_flags),  32'(me.fl));
      end
   end

   initial begin
      rst = 1'b1;
      u_push_n = 1'b1; u_pop_n = 1'b1; u_flush_n = 1'b1; u_din = '0; u_ae = 3'd1; u_af = 3'd1;
      d_push_n = 1'b1; d_pop_n = 1'b1; d_flush_n = 1'b1; d_din = '0; d_ae = 2'd1; d_af = 2'd1;
      @(negedge clk);
      do_reset_check();

      // four bytes pack into one MSB-first word, then pop it
      up_op(1, 0, 0, 8'h11); up_op(1, 0, 0, 8'h22); up_op(1, 0, 0, 8'h33);
      chk("pack_empty_before", 32'(u_empty), 32'h1);
      up_op(1, 0, 0, 8'h44);
      chk("pack_empty", 32'(u_empty), 32'h0);
      chk("pack_wc",    32'(u_wc),    32'h1);
      chk("pack_dout",  u_dout,       32'h11223344);
      up_op(0, 1, 0, 8'h00);
      chk("pop_empty",  32'(u_empty), 32'h1);

      // partial word flushed with zero fill
      up_op(1, 0, 0, 8'hAA); up_op(1, 0, 0, 8'hBB);
      chk("flush_part_before", 32'(u_part), 32'h1);
      up_op(0, 0, 1, 8'h00);
      chk("flush_part_after", 32'(u_part), 32'h0);
      chk("flush_wc",         32'(u_wc),   32'h1);
      chk("flush_dout",       u_dout,      32'hAABB0000);

      // two words plus a partial byte, then asynchronous reset
      for (int i = 0; i < 5; i++) up_op(1, 0, 0, 8'(8'h60 + i));
      chk("mid_wc",   32'(u_wc),   32'h2);
      chk("mid_part", 32'(u_part), 32'h1);
      do_reset_check();

      // fill to full, overflow, drain in order
      for (int i = 1; i <= 19; i++) up_op(1, 0, 0, 8'(i));
      chk("fill_ram_full", 32'(u_rfull), 32'h1);
      chk("fill_full",     32'(u_full),  32'h1);
      chk("fill_err_pre",  32'(u_err),   32'h0);
      up_op(1, 0, 0, 8'hEE);
      chk("ovf_err", 32'(u_err), 32'h1);
      chk("ovf_wc",  32'(u_wc),  32'h4);
      chk("drain0", u_dout, 32'h01020304); up_op(0, 1, 0, 8'h0);
      chk("drain1", u_dout, 32'h05060708); up_op(0, 1, 0, 8'h0);
      chk("drain2", u_dout, 32'h090A0B0C); up_op(0, 1, 0, 8'h0);
      chk("drain3", u_dout, 32'h0D0E0F10); up_op(0, 1, 0, 8'h0);
      chk("drain_empty", 32'(u_empty), 32'h1);
      do_reset_check();

      // underflow: sticky on the upsizer, one cycle on the downsizer
      step(0, 1, 0, 8'h0, 0, 1, 0, 32'h0);
      chk("uf_up_err", 32'(u_err), 32'h1);
      chk("uf_dn_err", 32'(d_err), 32'h1);
      step(0, 0, 0, 8'h0, 0, 0, 0, 32'h0);
      chk("uf_up_err_hold", 32'(u_err), 32'h1);
      chk("uf_dn_err_drop", 32'(d_err), 32'h0);

      // downsize LSB-first slicing
      dn_op(1, 0, 32'hDEADBEEF);
      chk("dn_s0", 32'(d_dout), 32'hEF); dn_op(0, 1, 32'h0);
      chk("dn_s1", 32'(d_dout), 32'hBE); dn_op(0, 1, 32'h0);
      chk("dn_s2", 32'(d_dout), 32'hAD); dn_op(0, 1, 32'h0);
      chk("dn_s3", 32'(d_dout), 32'hDE);
      chk("dn_nonempty", 32'(d_empty), 32'h0);
      dn_op(0, 1, 32'h0);
      chk("dn_empty", 32'(d_empty), 32'h1);
      do_reset_check();

      // randomized traffic with periodic level changes and resets
      for (int i = 0; i < 1600; i++) begin
         if (i % 50 == 0) begin
            u_ae = 3'($urandom_range(0, 4));
            u_af = 3'($urandom_range(0, 4));
            d_ae = 2'($urandom_range(0, 3));
            d_af = 2'($urandom_range(0, 3));
         end
         if (i % 400 == 399) do_reset_check();
         else step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                   $urandom_range(0, 99) < 12, 8'($urandom),
                   $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 60,
                   $urandom_range(0, 99) < 12, 32'($urandom));
      end
      step(0, 0, 0, 8'h0, 0, 0, 0, 32'h0);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
